// File: rtl/lsu_memory_stage.sv
// lsu_memory_stage: memory-stage load/store unit.
// Takes the EX/MEM register fields, runs one req/ack data-memory access per
// instruction, stalls the pipeline while the access is outstanding and returns
// sign/zero-extended load data to writeback.
// Optional feature macro: LSU_TIMEOUT_EN (BUSY watchdog raising o_bus_err).
module lsu_memory_stage #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_insn_vld_memory,
  input  logic        i_mem_wren_memory,
  input  logic [1:0]  i_wb_sel_memory,
  input  logic [2:0]  i_sl_sel_memory,
  input  logic [31:0] i_alu_data_memory,
  input  logic [31:0] i_pre_opb_memory,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_ld_vld,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_bus_err
);

  // The watchdog counter must be able to hold the timeout threshold.
  if (2**TMO_W <= TIMEOUT_CYC) begin : g_tmo_w_check
    $error("lsu_memory_stage: TMO_W too narrow for TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Access size encoding (funct3[1:0]; undefined encodings fold into word)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte enables for a given size and byte offset
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick it out
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] opb);
    logic [31:0] wd;
    case (size)
      SZ_B:    wd = {4{opb[7:0]}};
      SZ_H:    wd = {2{opb[15:0]}};
      default: wd = opb;
    endcase
    return wd;
  endfunction

  // Lane select plus sign/zero extension of a read word
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    res = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    res = {{16{sgn & half_v[15]}}, half_v};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_t      state_r;
  state_t      state_s;

  logic        load_s;
  logic        access_s;
  logic [1:0]  size_s;
  logic        signed_s;
  logic        misalign_s;

  logic        stall_s;
  logic        misalign_flag_s;
  logic        capture_s;
  logic        ack_take_s;
  logic        tmo_fire_s;
  logic        tmo_hit_s;

  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic        signed_r;

  logic [31:0] ld_data_r;
  logic        ld_vld_r;
  logic        bus_err_r;

  // Decode of the instruction currently presented by the EX/MEM register
  always_comb begin
    load_s   = (i_wb_sel_memory == 2'b01);
    access_s = i_insn_vld_memory & (i_mem_wren_memory | load_s);
    case (i_sl_sel_memory)
      3'b000, 3'b100: size_s = SZ_B;
      3'b001, 3'b101: size_s = SZ_H;
      default:        size_s = SZ_W;
    endcase
    signed_s = ~i_sl_sel_memory[2];
    case (size_s)
      SZ_B:    misalign_s = 1'b0;
      SZ_H:    misalign_s = i_alu_data_memory[0];
      default: misalign_s = (i_alu_data_memory[1:0] != 2'b00);
    endcase
  end

  // Next-state logic and the combinational strobes of each state
  always_comb begin
    state_s         = state_r;
    stall_s         = 1'b0;
    misalign_flag_s = 1'b0;
    capture_s       = 1'b0;
    ack_take_s      = 1'b0;
    tmo_fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s & ~misalign_s) begin
          stall_s   = 1'b1;
          capture_s = 1'b1;
          state_s   = ST_BUSY;
        end else if (access_s) begin
          misalign_flag_s = 1'b1;
          state_s         = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (i_dmem_ack) begin
          ack_take_s = 1'b1;
          state_s    = ST_DONE;
        end else if (tmo_hit_s) begin
          tmo_fire_s = 1'b1;
          state_s    = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      // DONE always retires so the still-presented instruction is not re-issued
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture of bus fields on the IDLE->BUSY transition, held stable until ack
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      we_r     <= 1'b0;
      addr_r   <= 32'h0000_0000;
      be_r     <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
      off_r    <= 2'b00;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
    end else if (capture_s) begin
      we_r     <= i_mem_wren_memory;
      addr_r   <= {i_alu_data_memory[31:2], 2'b00};
      be_r     <= lane_be(size_s, i_alu_data_memory[1:0]);
      wdata_r  <= lane_wdata(size_s, i_pre_opb_memory);
      off_r    <= i_alu_data_memory[1:0];
      size_r   <= size_s;
      signed_r <= signed_s;
    end else begin
      we_r     <= we_r;
      addr_r   <= addr_r;
      be_r     <= be_r;
      wdata_r  <= wdata_r;
      off_r    <= off_r;
      size_r   <= size_s == size_s ? size_r : size_r;
      signed_r <= signed_r;
    end
  end

  // Load result, load-valid and bus-error registers (one-cycle DONE strobes)
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ld_data_r <= 32'h0000_0000;
      ld_vld_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      ld_vld_r  <= ack_take_s & ~we_r;
      bus_err_r <= tmo_fire_s;
      if (ack_take_s & ~we_r) begin
        ld_data_r <= load_extend(i_dmem_rdata, size_r, off_r, signed_r);
      end else if (tmo_fire_s) begin
        ld_data_r <= 32'h0000_0000;
      end else begin
        ld_data_r <= ld_data_r;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Watchdog: counts BUSY cycles that end without an ack
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt_r <= '0;
    end else if (capture_s) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_BUSY) && !i_dmem_ack) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Fires in the BUSY cycle whose missing ack brings the count to TIMEOUT_CYC
  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Bus fields are only driven while the request is up; reset forces the
  // combinational strobes low as well so every output is 0 during reset.
  assign o_dmem_req   = (state_r == ST_BUSY);
  assign o_dmem_we    = o_dmem_req & we_r;
  assign o_dmem_addr  = o_dmem_req ? addr_r  : 32'h0000_0000;
  assign o_dmem_wdata = o_dmem_req ? wdata_r : 32'h0000_0000;
  assign o_dmem_be    = o_dmem_req ? be_r    : 4'b0000;
  assign o_ld_data    = ld_data_r;
  assign o_ld_vld     = ld_vld_r;
  assign o_bus_err    = bus_err_r;
  assign o_stall      = stall_s & i_reset;
  assign o_misalign   = misalign_flag_s & i_reset;

endmodule

// File: tb/tb_lsu_memory_stage.sv
// tb_lsu_memory_stage: directed plus randomized check of lsu_memory_stage
// against a byte-arithmetic reference model. Build with LSU_TIMEOUT_EN to
// exercise the watchdog (TIMEOUT_CYC is set to 4 here).
module tb_lsu_memory_stage;

  localparam int T_CYC = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        insn_vld;
  logic        mem_wren;
  logic [1:0]  wb_sel;
  logic [2:0]  sl_sel;
  logic [31:0] alu_data;
  logic [31:0] pre_opb;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_data;
  logic        ld_vld;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  int          cmp_n = 0;
  int          err_n = 0;
  logic [31:0] mdl_ld;

  always #5 clk = ~clk;

  lsu_memory_stage #(.TIMEOUT_CYC(T_CYC), .TMO_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_insn_vld_memory(insn_vld), .i_mem_wren_memory(mem_wren),
    .i_wb_sel_memory(wb_sel), .i_sl_sel_memory(sl_sel),
    .i_alu_data_memory(alu_data), .i_pre_opb_memory(pre_opb),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_ld_data(ld_data), .o_ld_vld(ld_vld), .o_stall(stall),
    .o_misalign(misalign), .o_bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: plain byte arithmetic on the access rules ----
  function automatic int nbytes(input logic [2:0] sl);
    case (sl)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] mdl_be(input int nb, input int off);
    if (nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] mdl_wdata(input int nb, input logic [31:0] opb);
    longint span, v, res;
    span = longint'(1) << (8 * nb);
    v    = longint'(opb) % span;
    res  = 0;
    for (int i = 0; i < 4 / nb; i++) res += v << (8 * nb * i);
    return 32'(res);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] rdata, input logic [2:0] sl, input int off);
    int nb;
    longint span, v;
    nb = nbytes(sl);
    if (nb == 4) return rdata;
    span = longint'(1) << (8 * nb);
    v    = (longint'(rdata) >> (8 * off)) % span;
    if (!sl[2] && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One instruction through the stage, checked every cycle against the model.
  task automatic access(input string tag, input logic vld, input logic we, input logic [1:0] wbs,
                        input logic [2:0] sl, input logic [31:0] addr, input logic [31:0] opb,
                        input int dly, input logic [31:0] rdata, input logic stray);
    bit acc, mis, ld, tmo;
    int nb, off, busy_n;
    acc    = vld && (we || wbs == 2'b01);
    nb     = nbytes(sl);
    off    = int'(addr[1:0]);
    mis    = (nb == 2 && (off % 2) != 0) || (nb == 4 && off != 0);
    ld     = acc && !we;
    tmo    = TMO_EN && (dly >= T_CYC);
    busy_n = tmo ? T_CYC : dly + 1;
    insn_vld = vld; mem_wren = we; wb_sel = wbs; sl_sel = sl; alu_data = addr; pre_opb = opb;
    #1;
    chk($sformatf("%s.idle_stall", tag), stall, acc && !mis);
    chk($sformatf("%s.idle_misal", tag), misalign, acc && mis);
    chk($sformatf("%s.idle_req", tag), dmem_req, 1'b0);
    tick;
    if (!acc || mis) begin
      insn_vld = 1'b0;
      #1;
      chk($sformatf("%s.noacc_req", tag), dmem_req, 1'b0);
      chk($sformatf("%s.noacc_stall", tag), stall, 1'b0);
      chk($sformatf("%s.noacc_ld", tag), ld_data, mdl_ld);
    end else begin
      for (int k = 0; k < busy_n; k++) begin
        dmem_ack   = !tmo && (k == dly);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        #1;
        chk($sformatf("%s.b%0d_req", tag, k), dmem_req, 1'b1);
        chk($sformatf("%s.b%0d_we", tag, k), dmem_we, we);
        chk($sformatf("%s.b%0d_addr", tag, k), dmem_addr, addr & 32'hFFFF_FFFC);
        chk($sformatf("%s.b%0d_be", tag, k), dmem_be, mdl_be(nb, off));
        if (we) chk($sformatf("%s.b%0d_wdata", tag, k), dmem_wdata, mdl_wdata(nb, opb));
        chk($sformatf("%s.b%0d_stall", tag, k), stall, 1'b1);
        chk($sformatf("%s.b%0d_ldvld", tag, k), ld_vld, 1'b0);
        tick;
        dmem_ack = 1'b0;
      end
      if (tmo) mdl_ld = 32'h0;
      else if (ld) mdl_ld = mdl_load(rdata, sl, off);
      chk($sformatf("%s.done_stall", tag), stall, 1'b0);
      chk($sformatf("%s.done_req", tag), dmem_req, 1'b0);
      chk($sformatf("%s.done_ldvld", tag), ld_vld, ld && !tmo);
      chk($sformatf("%s.done_buserr", tag), bus_err, tmo);
      chk($sformatf("%s.done_ld", tag), ld_data, mdl_ld);
      tick;
      insn_vld = 1'b0;
      #1;
      chk($sformatf("%s.ret_req", tag), dmem_req, 1'b0);
      chk($sformatf("%s.ret_stall", tag), stall, 1'b0);
      chk($sformatf("%s.ret_ldvld", tag), ld_vld, 1'b0);
      chk($sformatf("%s.ret_buserr", tag), bus_err, 1'b0);
    end
    // optional stray ack while idle: must be ignored
    dmem_ack   = stray;
    dmem_rdata = $urandom;
    tick;
    dmem_ack = 1'b0;
    chk($sformatf("%s.stray_ld", tag), ld_data, mdl_ld);
    chk($sformatf("%s.stray_ldvld", tag), ld_vld, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; insn_vld = 1'b0; mem_wren = 1'b0; wb_sel = 2'b00; sl_sel = 3'b000;
    alu_data = 32'h0; pre_opb = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    mdl_ld = 32'h0;
    #2;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_be", dmem_be, 4'h0);
    chk("rst_ld", ld_data, 32'h0);
    chk("rst_ldvld", ld_vld, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_misal", misalign, 1'b0);
    chk("rst_buserr", bus_err, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;

    // directed steps
    access("lw",   1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_1008, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    access("lb",   1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_1003, 32'h0, 3, 32'h80FF_FF00, 1'b1);
    access("lbu",  1'b1, 1'b0, 2'b01, 3'b100, 32'h0000_1003, 32'h0, 3, 32'h80FF_FF00, 1'b0);
    access("sh",   1'b1, 1'b1, 2'b00, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 1, 32'h5555_5555, 1'b0);
    access("lwmis",1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_2001, 32'h0, 0, 32'h0, 1'b1);
    access("nolsu",1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b1);
    access("novld",1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0);
    access("lhu",  1'b1, 1'b0, 2'b01, 3'b101, 32'h0000_4002, 32'h0, 0, 32'h9876_5432, 1'b0);
    access("lh",   1'b1, 1'b0, 2'b01, 3'b001, 32'h0000_4002, 32'h0, 2, 32'h9876_5432, 1'b0);
    access("sb",   1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_5001, 32'h0000_00A5, 0, 32'h0, 1'b0);
    access("sund", 1'b1, 1'b1, 2'b00, 3'b111, 32'h0000_6004, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
    access("noack",1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_7000, 32'h0, 10, 32'h1357_9BDF, 1'b0);

    // reset in the middle of an access
    insn_vld = 1'b1; mem_wren = 1'b0; wb_sel = 2'b01; sl_sel = 3'b010; alu_data = 32'h0000_3000;
    tick;
    chk("mrst_busy_req", dmem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_req", dmem_req, 1'b0);
    chk("mrst_stall", stall, 1'b0);
    chk("mrst_be", dmem_be, 4'h0);
    chk("mrst_addr", dmem_addr, 32'h0);
    chk("mrst_ld", ld_data, 32'h0);
    mdl_ld = 32'h0;
    insn_vld = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick;
    dmem_ack = 1'b0;
    #2 rst_n = 1'b1;
    tick;
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    #1;
    chk("mrst_stray_ld", ld_data, 32'h0);
    chk("mrst_stray_ldvld", ld_vld, 1'b0);
    chk("mrst_stray_req", dmem_req, 1'b0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic        vld_v, we_v, stray_v;
      logic [1:0]  wbs_v;
      logic [2:0]  sl_v;
      logic [31:0] a_v;
      int          nb_v;
      vld_v   = ($urandom_range(0, 7) != 0);
      we_v    = ($urandom_range(0, 2) == 0);
      wbs_v   = we_v ? 2'($urandom) : (($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01);
      sl_v    = 3'($urandom);
      a_v     = $urandom;
      nb_v    = nbytes(sl_v);
      if ($urandom_range(0, 3) != 0) begin
        if (nb_v == 4) a_v[1:0] = 2'b00;
        else if (nb_v == 2) a_v[0] = 1'b0;
      end
      stray_v = ($urandom_range(0, 3) == 0);
      access($sformatf("rnd%0d", i), vld_v, we_v, wbs_v, sl_v, a_v, $urandom,
             $urandom_range(0, 5), $urandom, stray_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/lsu_memory_stage.md
Name: lsu_memory_stage

Overview:
Memory-stage consumer of the execute/memory pipeline register. It takes the registered address, store data and load/store controls, and runs one data-memory access per instruction over a req/ack bus. It drives a pipeline stall while the access is outstanding and returns sign/zero-extended load data to the writeback mux.

Parameters:
TIMEOUT_CYC, 255, BUSY cycles without ack before a bus error (used only with LSU_TIMEOUT_EN)
TMO_W, 8, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYC

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_insn_vld_memory  in  1  instruction in memory stage is valid
i_mem_wren_memory  in  1  store
i_wb_sel_memory  in  2  2'b01 = load (writeback from memory); other values = no load
i_sl_sel_memory  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_alu_data_memory  in  32  effective byte address
i_pre_opb_memory  in  32  raw store data (rs2)
o_dmem_req  out  1  bus request, held until ack
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word address, bits [1:0] = 0
o_dmem_wdata  out  32  store data shifted into byte lanes
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  bus completion; one-cycle pulse
i_dmem_rdata  in  32  read word, valid with ack
o_ld_data  out  32  extended load result
o_ld_vld  out  1  o_ld_data valid this cycle
o_stall  out  1  freeze fetch/decode/execute and EX/MEM register
o_misalign  out  1  misaligned access flagged; no bus cycle issued
o_bus_err  out  1  timeout error (tied 0 without LSU_TIMEOUT_EN)

Behaviour:
- access = i_insn_vld_memory & (i_mem_wren_memory | i_wb_sel_memory==2'b01); size = sl_sel[1:0]; signed = ~sl_sel[2].
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Reset: state IDLE; every output 0; internal capture registers 0. Reset mid-access drops o_dmem_req immediately; the ack is not awaited.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access & ~misalign:
  - o_stall=1 combinationally.
  - Register we, addr, be and shifted wdata; go to BUSY.
- IDLE, access & misalign:
  - o_misalign=1 combinationally for that cycle; no stall, no request; stay in IDLE.
- IDLE, no access: outputs idle, no stall.
- BUSY:
  - o_dmem_req=1 with registered fields, held stable until ack; o_stall=1.
  - On i_dmem_ack: register extended load data into o_ld_data and go to DONE. For stores, o_ld_data is left unchanged.
- DONE:
  - o_stall=0 so the pipeline advances; o_ld_vld=1 for loads only.
  - Go to IDLE unconditionally. This prevents re-issue of the same still-presented instruction.
- Minimum access latency is 3 cycles (IDLE, BUSY with same-cycle ack, DONE). Each extra wait cycle adds 1.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{opb[7:0]}}.
  - H: be = 4'b0011 << addr[1:0], wdata = {2{opb[15:0]}}.
  - W: be = 4'b1111, wdata = opb.
- Loads: be uses the same lane rules, we=0. Lane select is by the captured addr[1:0]; sign- or zero-extend to 32 bits.
- Ack outside BUSY is ignored. i_dmem_rdata is sampled only with ack in BUSY.
- Undefined sl_sel (011, 110, 111) on an access is treated as W.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A TMO_W-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC: drop req, pulse o_bus_err for 1 cycle, go to DONE with o_ld_vld=0 and o_ld_data=0.
- Undefined: no counter; BUSY waits indefinitely; o_bus_err tied 0.

Test Plan:
- LW: addr 0x0000_1008, ack on the first BUSY cycle, rdata 0xDEAD_BEEF. Required: req asserted 1 cycle, addr 0x1008, be 1111, stall for 2 cycles, then DONE with o_ld_vld=1 and o_ld_data 0xDEAD_BEEF.
- LB vs LBU: addr 0x1003, rdata 0x80FF_FF00 with ack delayed 3 cycles. Required: LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; stall lasts 5 cycles; addr/be stable (0x1000, 1000) throughout BUSY.
- SH: addr 0x2002, opb 0x1234_ABCD. Required: we=1, be 1100, wdata 0xABCD_ABCD; no o_ld_vld.
- Misaligned LW at 0x2001. Required: o_misalign=1 for 1 cycle, no o_dmem_req, no stall. Non-access instructions produce no req and no stall.
- Reset mid-access: assert i_reset=0 during BUSY. Required: req, stall and all outputs go to 0 immediately; a later stray ack is ignored.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack. Required: o_bus_err pulses after 4 BUSY cycles, req drops, o_ld_vld=0, FSM returns to IDLE.
